single_to_fix: RTL and testbench

- Converts an IEEE-754 single-precision value into an unsigned INT_WIDTH.FRACT_WIDTH fixed-point word.
- Inverse neighbour of the fixed-to-single stage. Sits directly downstream of the fast inverse-sqrt datapath, returning its float result to the fixed-point Madgwick filter arithmetic.
- Multi-cycle FSM with a valid/ready handshake on both sides; saturates and flags out-of-range inputs.

---
 rtl/single_to_fix.sv | 104 ++++++++++
 tb/tb_single_to_fix.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/single_to_fix.sv
// single_to_fix: IEEE-754 single to unsigned INT.FRACT fixed point, round-half-up when SINGLE_TO_FIX_ROUND_EN is defined
module single_to_fix #(
  parameter int INT_WIDTH = 8,
  parameter int FRACT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic [31:0]                      single_in,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0] data_out,
  output logic                             overflow,
  output logic                             underflow,
  output logic                             neg_sat
);
  localparam int W = INT_WIDTH + FRACT_WIDTH;
`ifdef SINGLE_TO_FIX_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, DECODE, ALIGN, ROUND, OUT} state_t;
  state_t state_q;
  logic [31:0] in_q;
  logic zero_q, spec_q, neg_q, guard_q, big_q;
  logic [9:0] sh_q;
  logic [W-1:0] val_q;
  logic zero_d, spec_d, neg_d, guard_d, big_d, left, flow, ovf_d, unf_d;
  logic [9:0] sh_d, rsh;
  logic [24:0] shr;
  logic [W+23:0] wide;
  logic [W:0] sum;
  logic [W-1:0] res_d;
  assign ready_in = state_q == IDLE && !rst;
  always_comb begin
    zero_d = in_q[30:23] == 8'd0;
    spec_d = &in_q[30:23];
    neg_d = in_q[31] && !zero_d && !spec_d;
    sh_d = 10'(in_q[30:23]) + 10'(FRACT_WIDTH - 150);
    left = !sh_q[9];
    rsh = -sh_q;
    shr = {1'b1, in_q[22:0], 1'b0} >> rsh;
    wide = left ? {{W{1'b0}}, 1'b1, in_q[22:0]} << sh_q[5:0]
                : {{W{1'b0}}, rsh > 10'd24 ? 24'd0 : shr[24:1]};
    big_d = (left && sh_q >= 10'(W)) || |wide[W+23:W];
    guard_d = !left && rsh < 10'd25 && shr[0];
    sum = {1'b0, val_q} + (W+1)'(guard_q && RND);
    flow = spec_q || big_q || sum[W];
    res_d = zero_q || neg_q ? '0 : flow ? '1 : sum[W-1:0];
    ovf_d = !zero_q && !neg_q && flow;
    unf_d = !zero_q && !neg_q && !flow && sum[W-1:0] == '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      in_q <= '0;
      zero_q <= 1'b0;
      spec_q <= 1'b0;
      neg_q <= 1'b0;
      guard_q <= 1'b0;
      big_q <= 1'b0;
      sh_q <= '0;
      val_q <= '0;
      valid_out <= 1'b0;
      data_out <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      neg_sat <= 1'b0;
    end else
      case (state_q)
        IDLE: if (valid_in) begin
          in_q <= single_in;
          state_q <= DECODE;
        end
        DECODE: begin
          zero_q <= zero_d;
          spec_q <= spec_d;
          neg_q <= neg_d;
          sh_q <= sh_d;
          state_q <= ALIGN;
        end
        ALIGN: begin
          val_q <= wide[W-1:0];
          guard_q <= guard_d;
          big_q <= big_d;
          state_q <= ROUND;
        end
        ROUND: begin
          data_out <= res_d;
          overflow <= ovf_d;
          underflow <= unf_d;
          neg_sat <= neg_q;
          state_q <= OUT;
        end
        OUT: if (!valid_out) valid_out <= 1'b1;
        else if (ready_out) begin
          valid_out <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_single_to_fix.sv
// tb_single_to_fix: randomized check of single_to_fix against an arithmetic reference model
module tb_single_to_fix;
  localparam int IW = 8;
  localparam int FW = 8;
  localparam int W = IW + FW;
`ifdef SINGLE_TO_FIX_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, ready_out = 1'b0;
  logic [31:0] single_in = '0;
  logic ready_in, valid_out, overflow, underflow, neg_sat;
  logic [W-1:0] data_out;
  int errors = 0, checks = 0;
  single_to_fix #(.INT_WIDTH(IW), .FRACT_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .single_in(single_in), .valid_out(valid_out), .ready_out(ready_out),
    .data_out(data_out), .overflow(overflow), .underflow(underflow), .neg_sat(neg_sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [31:0] f, output logic [W-1:0] d, output logic [2:0] fl);
    int ex, e;
    longint unsigned m, v;
    ex = int'(f[30:23]);
    m = {40'd0, 1'b1, f[22:0]};
    d = '0;
    fl = 3'b000;
    if (ex == 0) return;
    if (ex == 255) begin
      d = '1;
      fl = 3'b100;
      return;
    end
    if (f[31]) begin
      fl = 3'b001;
      return;
    end
    e = ex - 150 + FW;
    if (e >= 40) v = 64'd1 << 40;
    else if (e >= 0) v = m << e;
    else if (-e >= 62) v = 0;
    else v = (m + (RND ? 64'd1 << (-e - 1) : 64'd0)) >> (-e);
    if (v >= (64'd1 << W)) begin
      d = '1;
      fl = 3'b100;
    end else begin
      d = W'(v);
      fl = {1'b0, v == 0, 1'b0};
    end
  endfunction
  task automatic run(input logic [31:0] f, input int stall);
    logic [W-1:0] ed;
    logic [2:0] ef;
    int lat;
    model(f, ed, ef);
    chk("ready_in_idle", ready_in, 1);
    ready_out = stall == 0;
    single_in = f;
    valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    single_in = $urandom();
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!valid_out && lat < 12);
    chk($sformatf("latency %h", f), lat, 4);
    chk($sformatf("data %h", f), data_out, ed);
    chk($sformatf("flags %h", f), {overflow, underflow, neg_sat}, ef);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", valid_out, 1);
      chk("hold_data", data_out, ed);
      chk("hold_flags", {overflow, underflow, neg_sat}, ef);
      chk("hold_ready_in", ready_in, 0);
    end
    @(negedge clk);
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    chk("xfer_valid", valid_out, 0);
    chk("xfer_ready_in", ready_in, 1);
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] dir [12];
    logic [31:0] f;
    logic seen;
    dir = '{32'h3F800000, 32'h40200000, 32'h40A40000, 32'h3B000000, 32'h437FFF80, 32'h43800000,
            32'h7F800000, 32'h7FC00000, 32'hBF800000, 32'h80000000, 32'h00000001, 32'hFF800000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_flags", {overflow, underflow, neg_sat}, 0);
    chk("rst_ready_in", ready_in, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) run(dir[i], i == 2 ? 6 : 0);
    run(32'h40A40000, 0);
    single_in = 32'h40200000;
    valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid", valid_out, 0);
    chk("abort_data", data_out, 0);
    chk("abort_ready_in", ready_in, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen |= valid_out;
    end
    chk("abort_no_output", seen, 0);
    @(negedge clk);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) f = $urandom();
      else f = {$urandom_range(0, 7) == 0, 8'($urandom_range(105, 140)), 23'($urandom())};
      run(f, $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
